// File: rtl/nbit_arb_mux_reg_if.sv
// Handshake bundle for the arbitrating mux: CH producer channels in, one registered consumer port out.
// The slave modport is the arbiter's view; master is the producer/consumer side.
interface nbit_arb_mux_reg_if #(
    parameter int N  = 8,
    parameter int CH = 4
);
    localparam int SW = (CH > 1) ? $clog2(CH) : 1;

    logic [CH*N-1:0] in_data;
    logic [CH-1:0]   in_valid;
    logic [CH-1:0]   in_ready;
    logic [N-1:0]    out_data;
    logic            out_valid;
    logic            out_ready;
    logic [SW-1:0]   out_sel;

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_sel
    );

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_sel
    );
endinterface

// File: rtl/nbit_arb_mux_reg.sv
// Registered CH-channel arbitrating mux: round-robin or fixed-priority grant into a
// one-entry output register with valid/ready on both sides.
module nbit_arb_mux_reg #(
    parameter int N    = 8,
    parameter int CH   = 4,
    parameter int MODE = 0
) (
    input logic               clk,
    input logic               rst_n,
    nbit_arb_mux_reg_if.slave bus
);
    localparam int SW = (CH > 1) ? $clog2(CH) : 1;

    logic [N-1:0]  data_q;
    logic [SW-1:0] sel_q;
    logic          valid_q;
    logic [SW-1:0] rr_ptr;

    logic [CH-1:0] grant;
    logic [SW-1:0] win;
    logic [SW-1:0] scan;
    logic          found;
    logic          accept_en;
    logic          xfer;

    // Scan channels starting at rr_ptr (round-robin) or at 0 (fixed priority); first valid wins.
    always_comb begin
        grant = '0;
        win   = '0;
        scan  = '0;
        found = 1'b0;
        for (int k = 0; k < CH; k++) begin
            if (MODE == 1)
                scan = SW'(k);
            else
                scan = SW'((int'(rr_ptr) + k) % CH);
            if (!found && bus.in_valid[scan]) begin
                found       = 1'b1;
                win         = scan;
                grant[scan] = 1'b1;
            end
        end
    end

    assign accept_en    = !valid_q || bus.out_ready;
    assign xfer         = found && accept_en;
    assign bus.in_ready = grant & {CH{accept_en}};

    // A new word always overwrites the register; valid only drops when drained with nothing to replace it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
            rr_ptr  <= '0;
        end else if (xfer) begin
            data_q  <= bus.in_data[int'(win)*N +: N];
            sel_q   <= win;
            valid_q <= 1'b1;
            if (MODE == 0)
                rr_ptr <= (int'(win) == CH - 1) ? '0 : win + 1'b1;
        end else if (bus.out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.out_data  = data_q;
    assign bus.out_sel   = sel_q;
    assign bus.out_valid = valid_q;
endmodule

// File: tb/tb_nbit_arb_mux_reg.sv
// Drives a round-robin and a fixed-priority instance with identical stimulus and checks
// both against a queue-free arbitration model every cycle, plus hand-computed spot checks.
module tb_nbit_arb_mux_reg;
    localparam int N  = 8;
    localparam int CH = 4;
    localparam int SW = (CH > 1) ? $clog2(CH) : 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [CH*N-1:0] in_data = '0;
    logic [CH-1:0]   in_valid = '0;
    logic            out_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nbit_arb_mux_reg_if #(.N(N), .CH(CH)) bus0 ();
    nbit_arb_mux_reg_if #(.N(N), .CH(CH)) bus1 ();

    assign bus0.in_data   = in_data;
    assign bus0.in_valid  = in_valid;
    assign bus0.out_ready = out_ready;
    assign bus1.in_data   = in_data;
    assign bus1.in_valid  = in_valid;
    assign bus1.out_ready = out_ready;

    nbit_arb_mux_reg #(.N(N), .CH(CH), .MODE(0)) dut_rr (.clk(clk), .rst_n(rst_n), .bus(bus0));
    nbit_arb_mux_reg #(.N(N), .CH(CH), .MODE(1)) dut_fp (.clk(clk), .rst_n(rst_n), .bus(bus1));

    // Model state, index 0 = round-robin, 1 = fixed priority
    logic         m_valid [2];
    logic [N-1:0] m_data  [2];
    int           m_sel   [2];
    int           m_ptr   [2];

    function automatic int pick(int mode, int ptr, logic [CH-1:0] v);
        for (int k = 0; k < CH; k++) begin
            int c;
            c = (mode == 1) ? k : (ptr + k) % CH;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [CH-1:0] exp_ready(int m);
        int g;
        logic [CH-1:0] r;
        r = '0;
        g = pick(m, m_ptr[m], in_valid);
        if (g >= 0 && (!m_valid[m] || out_ready)) r[g] = 1'b1;
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int m = 0; m < 2; m++) begin
                m_valid[m] <= 1'b0;
                m_data[m]  <= '0;
                m_sel[m]   <= 0;
                m_ptr[m]   <= 0;
            end
        end else begin
            for (int m = 0; m < 2; m++) begin
                int g;
                g = pick(m, m_ptr[m], in_valid);
                if (g >= 0 && (!m_valid[m] || out_ready)) begin
                    m_valid[m] <= 1'b1;
                    m_data[m]  <= in_data[g*N +: N];
                    m_sel[m]   <= g;
                    if (m == 0) m_ptr[m] <= (g + 1) % CH;
                end else if (out_ready) begin
                    m_valid[m] <= 1'b0;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic compareDut(input int m, input logic ov, input logic [N-1:0] od,
                              input logic [SW-1:0] os, input logic [CH-1:0] ir);
        checkOutput($sformatf("m%0d_out_valid", m), 32'(ov), 32'(m_valid[m]));
        checkOutput($sformatf("m%0d_out_data", m), 32'(od), 32'(m_data[m]));
        checkOutput($sformatf("m%0d_out_sel", m), 32'(os), 32'(m_sel[m]));
        checkOutput($sformatf("m%0d_in_ready", m), 32'(ir), 32'(exp_ready(m)));
    endtask

    always @(negedge clk) begin
        compareDut(0, bus0.out_valid, bus0.out_data, bus0.out_sel, bus0.in_ready);
        compareDut(1, bus1.out_valid, bus1.out_data, bus1.out_sel, bus1.in_ready);
    end

    task automatic applyStimulus(input logic [CH-1:0] v, input logic [CH*N-1:0] d, input logic r);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        #1;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [CH*N-1:0] rand_data();
        logic [CH*N-1:0] d;
        for (int i = 0; i < CH; i++) d[i*N +: N] = N'($urandom);
        return d;
    endfunction

    logic [CH*N-1:0] base;
    logic [CH*N-1:0] with_a5;

    initial begin
        for (int i = 0; i < CH; i++) base[i*N +: N] = N'(8'h10 + i);
        with_a5 = base;
        with_a5[2*N +: N] = 8'hA5;

        // Reset with random inputs
        applyStimulus(CH'($urandom), rand_data(), 1'($urandom));
        tick(3);
        checkOutput("rst_valid", 32'(bus0.out_valid), 0);
        checkOutput("rst_data", 32'(bus0.out_data), 0);
        checkOutput("rst_sel", 32'(bus0.out_sel), 0);
        rst_n = 1'b1;
        applyStimulus(4'hF, base, 1'b1);
        checkOutput("rst_first_grant", 32'(bus0.in_ready), 32'h1);

        // Round-robin sequence 0,1,2,3,0,1,2,3
        for (int k = 0; k < 8; k++) begin
            tick(1);
            checkOutput("rr_sel", 32'(bus0.out_sel), 32'(k % 4));
            checkOutput("rr_data", 32'(bus0.out_data), 32'(8'h10 + k % 4));
            checkOutput("rr_valid", 32'(bus0.out_valid), 1);
            checkOutput("rr_onehot", 32'($countones(bus0.in_ready)), 1);
        end

        // Fixed priority starves ch3 while ch1 requests
        applyStimulus(4'b1010, base, 1'b1);
        for (int k = 0; k < 4; k++) begin
            checkOutput("fp_ready", 32'(bus1.in_ready), 32'b0010);
            tick(1);
            checkOutput("fp_sel", 32'(bus1.out_sel), 1);
        end
        applyStimulus(4'b1000, base, 1'b1);
        checkOutput("fp_ready_ch3", 32'(bus1.in_ready), 32'b1000);
        tick(1);
        checkOutput("fp_sel_ch3", 32'(bus1.out_sel), 3);

        // Backpressure holding ch2 word A5
        applyStimulus(4'b0100, with_a5, 1'b1);
        tick(1);
        applyStimulus(4'hF, with_a5, 1'b0);
        for (int k = 0; k < 5; k++) begin
            checkOutput("bp_data", 32'(bus0.out_data), 32'hA5);
            checkOutput("bp_sel", 32'(bus0.out_sel), 2);
            checkOutput("bp_valid", 32'(bus0.out_valid), 1);
            checkOutput("bp_ready", 32'(bus0.in_ready), 0);
            checkOutput("bp_ready_fp", 32'(bus1.in_ready), 0);
            tick(1);
        end

        // Wrap from ptr 3 to ch0, then idle leaves ptr at 1
        applyStimulus(4'b0001, base, 1'b1);
        checkOutput("wrap_ready", 32'(bus0.in_ready), 32'b0001);
        tick(1);
        checkOutput("wrap_sel", 32'(bus0.out_sel), 0);
        applyStimulus(4'b0000, base, 1'b1);
        tick(3);
        checkOutput("idle_drained", 32'(bus0.out_valid), 0);
        applyStimulus(4'hF, base, 1'b1);
        checkOutput("idle_ptr_kept", 32'(bus0.in_ready), 32'b0010);
        tick(1);
        checkOutput("idle_sel", 32'(bus0.out_sel), 1);

        // Asynchronous reset during a stall discards the word
        applyStimulus(4'b0100, with_a5, 1'b1);
        tick(1);
        applyStimulus(4'b0000, with_a5, 1'b0);
        tick(2);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_valid_rr", 32'(bus0.out_valid), 0);
        checkOutput("arst_valid_fp", 32'(bus1.out_valid), 0);
        checkOutput("arst_data", 32'(bus0.out_data), 0);
        tick(2);
        rst_n = 1'b1;
        applyStimulus(4'b0000, with_a5, 1'b1);
        for (int k = 0; k < 3; k++) begin
            tick(1);
            checkOutput("arst_no_deliver", 32'(bus0.out_valid), 0);
        end

        // Mixed traffic checked by the model alone
        for (int k = 0; k < 40; k++) begin
            applyStimulus(CH'($urandom), rand_data(), 1'($urandom_range(0, 1)));
            tick(1);
        end

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
